// File: rtl/morse_pkg.sv
// Shared definitions for the Morse key front-end and the sequence_producer
// that consumes its symbol stream.
package morse_pkg;

   localparam int MAX_SYMBOLS = 5;

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      GAP,
      WORD_WAIT
   } key_state_t;

endpackage

// File: rtl/morse_key_timer_if.sv
// Key input and symbol pulse outputs of morse_key_timer, grouped as one bundle.
// master drives the key; slave is the timer producing the pulses.
interface morse_key_timer_if;

   logic       Key;
   logic       Dot;
   logic       Dash;
   logic       Space;
   logic       EndSeq;
   logic       Overrun;
   logic [2:0] SymCount;

   modport master (
      output Key,
      input  Dot, Dash, Space, EndSeq, Overrun, SymCount
   );

   modport slave (
      input  Key,
      output Dot, Dash, Space, EndSeq, Overrun, SymCount
   );

endinterface

// File: rtl/morse_key_timer_debouncer.sv
// Two-flop synchronizer followed by a stability filter: key_d follows the
// synchronized key only after it has disagreed for DEBOUNCE consecutive cycles.
module key_debouncer #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic srst,
   input  logic key,
   output logic key_d
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);

   logic          sync1_reg;
   logic          key_s_reg;
   logic          key_d_reg;
   logic [DW-1:0] stable_cnt_reg;

   // Rise and fall use the same filter, so press length is preserved exactly.
   always_ff @(posedge clk) begin
      if (srst) begin
         sync1_reg      <= 1'b0;
         key_s_reg      <= 1'b0;
         key_d_reg      <= 1'b0;
         stable_cnt_reg <= '0;
      end else begin
         sync1_reg <= key;
         key_s_reg <= sync1_reg;
         if (key_s_reg != key_d_reg) begin
            if (stable_cnt_reg == CNT_LAST) begin
               key_d_reg      <= key_s_reg;
               stable_cnt_reg <= '0;
            end else begin
               stable_cnt_reg <= stable_cnt_reg + DW'(1);
            end
         end else begin
            stable_cnt_reg <= '0;
         end
      end
   end

   assign key_d = key_d_reg;

endmodule

// File: rtl/morse_key_timer.sv
// Classifies debounced key presses into Dot/Dash and silences into Space/EndSeq
// pulses, capping each letter at MAX_SYMBOLS symbols.
module morse_key_timer
   import morse_pkg::*;
#(
   parameter int CW        = 16,
   parameter int DEBOUNCE  = 4,
   parameter int DASH_MIN  = 300,
   parameter int SPACE_GAP = 900,
   parameter int END_GAP   = 2100
) (
   input  logic               Clk,
   input  logic               Reset,
   morse_key_timer_if.slave   kt
);

   localparam logic [CW-1:0] CNT_MAX     = '1;
   localparam logic [CW-1:0] DASH_MIN_C  = CW'(DASH_MIN);
   localparam logic [CW-1:0] SPACE_GAP_C = CW'(SPACE_GAP);
   localparam logic [CW-1:0] END_GAP_C   = CW'(END_GAP);
   localparam logic [2:0]    MAX_SYM_C   = 3'(MAX_SYMBOLS);

   logic key_d;

   key_debouncer #(
      .DEBOUNCE(DEBOUNCE)
   ) u_debouncer (
      .clk   (Clk),
      .srst  (Reset),
      .key   (kt.Key),
      .key_d (key_d)
   );

   key_state_t    state_reg, state_next;
   logic [CW-1:0] press_cnt_reg, press_cnt_next;
   logic [CW-1:0] gap_cnt_reg, gap_cnt_next;
   logic [2:0]    sym_cnt_reg, sym_cnt_next;
   logic          dot_reg, dot_next;
   logic          dash_reg, dash_next;
   logic          space_reg, space_next;
   logic          end_reg, end_next;
   logic          overrun_reg, overrun_next;

   logic [CW-1:0] press_inc;
   logic [CW-1:0] gap_inc;

   assign press_inc = (press_cnt_reg == CNT_MAX) ? press_cnt_reg : press_cnt_reg + CW'(1);
   assign gap_inc   = (gap_cnt_reg == CNT_MAX) ? gap_cnt_reg : gap_cnt_reg + CW'(1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg     <= IDLE;
         press_cnt_reg <= '0;
         gap_cnt_reg   <= '0;
         sym_cnt_reg   <= '0;
         dot_reg       <= 1'b0;
         dash_reg      <= 1'b0;
         space_reg     <= 1'b0;
         end_reg       <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         press_cnt_reg <= press_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         sym_cnt_reg   <= sym_cnt_next;
         dot_reg       <= dot_next;
         dash_reg      <= dash_next;
         space_reg     <= space_next;
         end_reg       <= end_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      press_cnt_next = press_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      sym_cnt_next   = sym_cnt_reg;
      dot_next       = 1'b0;
      dash_next      = 1'b0;
      space_next     = 1'b0;
      end_next       = 1'b0;
      overrun_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (key_d) begin
               state_next     = PRESS;
               press_cnt_next = CW'(1);
            end
         end

         PRESS: begin
            if (key_d) begin
               press_cnt_next = press_inc;
            end else begin
               state_next   = GAP;
               gap_cnt_next = '0;
               // A full letter swallows further presses but still reports them.
               if (sym_cnt_reg < MAX_SYM_C) begin
                  if (press_cnt_reg < DASH_MIN_C) begin
                     dot_next = 1'b1;
                  end else begin
                     dash_next = 1'b1;
                  end
                  sym_cnt_next = sym_cnt_reg + 3'd1;
               end else begin
                  overrun_next = 1'b1;
               end
            end
         end

         GAP: begin
            if (key_d) begin
               state_next     = PRESS;
               press_cnt_next = CW'(1);
            end else begin
               gap_cnt_next = gap_inc;
               if (gap_inc >= SPACE_GAP_C) begin
                  state_next   = WORD_WAIT;
                  space_next   = 1'b1;
                  sym_cnt_next = '0;
               end
            end
         end

         WORD_WAIT: begin
            // gap_cnt keeps running from the last symbol, so EndSeq is timed from it too.
            if (key_d) begin
               state_next     = PRESS;
               press_cnt_next = CW'(1);
            end else begin
               gap_cnt_next = gap_inc;
               if (gap_inc >= END_GAP_C) begin
                  state_next = IDLE;
                  end_next   = 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign kt.Dot      = dot_reg;
   assign kt.Dash     = dash_reg;
   assign kt.Space    = space_reg;
   assign kt.EndSeq   = end_reg;
   assign kt.Overrun  = overrun_reg;
   assign kt.SymCount = sym_cnt_reg;

endmodule

// File: tb/tb_morse_key_timer.sv
// Self-checking bench for morse_key_timer: constant-expectation vector table,
// hand-written corner sequences, and random key waveforms against a timeline model.
`timescale 1ns/1ps
module tb_morse_key_timer;

   localparam int CW        = 8;
   localparam int DEBOUNCE  = 2;
   localparam int DASH_MIN  = 5;
   localparam int SPACE_GAP = 8;
   localparam int END_GAP   = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   morse_key_timer_if kt_if();

   morse_key_timer #(
      .CW        (CW),
      .DEBOUNCE  (DEBOUNCE),
      .DASH_MIN  (DASH_MIN),
      .SPACE_GAP (SPACE_GAP),
      .END_GAP   (END_GAP)
   ) dut (
      .Clk   (clk),
      .Reset (reset),
      .kt    (kt_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   bit         wave[$];
   logic [7:0] exp_q[$];
   byte        ev_code[$];
   int         ev_t[$];
   string      ev_str;

   typedef struct {
      int hi_len;
      int kind;      // 0 none, 1 dot, 2 dash
      int first_t;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic check_str(input string name, input string got, input string want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, want);
      end
   endtask

   function automatic logic [7:0] outs();
      return {kt_if.Dot, kt_if.Dash, kt_if.Space, kt_if.EndSeq, kt_if.Overrun, kt_if.SymCount};
   endfunction

   task automatic add_run(input bit lvl, input int len);
      for (int i = 0; i < len; i++) wave.push_back(lvl);
   endtask

   // Timeline model: filter the raw key, then derive pulses from press lengths
   // and the silence elapsed since the last reported symbol.
   task automatic compute_model();
      int n;
      int run;
      int ones1, ones2, ones_t;
      int cnt;
      int lp;
      bit pressed;
      bit kd1, kd2, kd_t, ks;
      logic [7:0] e;
      n = wave.size();
      run = 0; ones1 = 0; ones2 = 0; cnt = 0; lp = -1; pressed = 0;
      kd1 = 0; kd2 = 0;
      exp_q.delete();
      for (int t = 0; t < n; t++) begin
         e = '0;
         ks = (t >= 2) ? wave[t-2] : 1'b0;
         kd_t = kd1;
         if (ks != kd1) begin
            run++;
            if (run >= DEBOUNCE) begin
               kd_t = ks;
               run  = 0;
            end
         end else begin
            run = 0;
         end

         if (kd2 && !kd1) begin
            if (cnt < 5) begin
               if (ones2 < DASH_MIN) e[7] = 1'b1;
               else e[6] = 1'b1;
               cnt++;
            end else begin
               e[3] = 1'b1;
            end
            lp = t;
            pressed = 0;
         end else if (kd1) begin
            pressed = 1;
         end else if (lp >= 0 && !pressed) begin
            if (t - lp == SPACE_GAP) begin
               e[5] = 1'b1;
               cnt = 0;
            end else if (t - lp == END_GAP) begin
               e[4] = 1'b1;
               lp = -1;
            end
         end
         e[2:0] = 3'(cnt);
         exp_q.push_back(e);

         ones_t = kd_t ? ones1 + 1 : 0;
         ones2 = ones1; ones1 = ones_t;
         kd2 = kd1; kd1 = kd_t;
      end
   endtask

   task automatic log_event(input string tag, input int t, input byte c, input logic [2:0] sc);
      ev_code.push_back(c);
      ev_t.push_back(t);
      ev_str = $sformatf("%s%c", ev_str, c);
      $display("%s t=%0d event %c symcount %0d", tag, t, c, sc);
   endtask

   task automatic run_wave(input bit pre_key, input string tag);
      logic [7:0] got;
      compute_model();
      ev_code.delete();
      ev_t.delete();
      ev_str = "";
      reset = 1'b1;
      kt_if.Key = pre_key;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      kt_if.Key = (wave.size() > 0) ? wave[0] : 1'b0;
      for (int t = 0; t < wave.size(); t++) begin
         @(posedge clk);
         #1;
         got = outs();
         check($sformatf("%s cycle %0d outputs", tag, t), 32'(got), 32'(exp_q[t]));
         if (got[7] === 1'b1) log_event(tag, t, "o", got[2:0]);
         if (got[6] === 1'b1) log_event(tag, t, "a", got[2:0]);
         if (got[5] === 1'b1) log_event(tag, t, "s", got[2:0]);
         if (got[4] === 1'b1) log_event(tag, t, "e", got[2:0]);
         if (got[3] === 1'b1) log_event(tag, t, "x", got[2:0]);
         kt_if.Key = (t + 1 < wave.size()) ? wave[t+1] : 1'b0;
      end
   endtask

   initial begin
      int nz;
      byte want_c;

      // Reset held with the key toggling: outputs stay quiet throughout and after.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         kt_if.Key = i[0];
         @(posedge clk);
         #1;
         check($sformatf("reset hold %0d", i), 32'(outs()), 32'd0);
      end
      reset = 1'b0;
      kt_if.Key = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("after reset %0d", i), 32'(outs()), 32'd0);
      end

      // Single presses: raw length -> symbol kind and release+4 edge position.
      vecs[0] = '{1, 0, 0};
      vecs[1] = '{2, 1, 6};
      vecs[2] = '{3, 1, 7};
      vecs[3] = '{4, 1, 8};
      vecs[4] = '{5, 2, 9};
      vecs[5] = '{6, 2, 10};
      vecs[6] = '{40, 2, 44};
      vecs[7] = '{300, 2, 304};
      for (int i = 0; i < 8; i++) begin
         wave.delete();
         add_run(1'b1, vecs[i].hi_len);
         add_run(1'b0, 120);
         run_wave(1'b0, $sformatf("vec%0d", i));
         if (vecs[i].kind == 0) begin
            check($sformatf("vec%0d event count", i), ev_code.size(), 0);
         end else begin
            check($sformatf("vec%0d event count", i), ev_code.size(), 3);
            if (ev_code.size() >= 3) begin
               want_c = (vecs[i].kind == 1) ? "o" : "a";
               check($sformatf("vec%0d symbol kind", i), 32'(ev_code[0]), 32'(want_c));
               check($sformatf("vec%0d symbol time", i), ev_t[0], vecs[i].first_t);
               check($sformatf("vec%0d space kind", i), 32'(ev_code[1]), 32'("s"));
               check($sformatf("vec%0d space delay", i), ev_t[1] - ev_t[0], SPACE_GAP);
               check($sformatf("vec%0d endseq kind", i), 32'(ev_code[2]), 32'("e"));
               check($sformatf("vec%0d endseq delay", i), ev_t[2] - ev_t[0], END_GAP);
            end
         end
      end

      // Letter L: dot dash dot dot.
      wave.delete();
      add_run(1, 3); add_run(0, 4); add_run(1, 6); add_run(0, 4);
      add_run(1, 3); add_run(0, 4); add_run(1, 3); add_run(0, 40);
      run_wave(1'b0, "letterL");
      check_str("letterL events", ev_str, "oaoose");

      // Six presses: the sixth is discarded as an overrun.
      wave.delete();
      for (int i = 0; i < 6; i++) begin
         add_run(1, 3);
         add_run(0, 4);
      end
      add_run(0, 40);
      run_wave(1'b0, "overrun");
      check_str("overrun events", ev_str, "oooooxse");

      // Press after Space but before EndSeq opens a new letter in the same message.
      wave.delete();
      add_run(1, 3); add_run(0, 10); add_run(1, 3); add_run(0, 40);
      run_wave(1'b0, "newletter");
      check_str("newletter events", ev_str, "osose");

      // Reset while key_d is high discards the press.
      reset = 1'b1;
      kt_if.Key = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      kt_if.Key = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      kt_if.Key = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      nz = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (outs() != 8'd0) nz++;
      end
      check("midpress reset pulses", nz, 0);

      // Key still held across reset: counted as a fresh press once released.
      kt_if.Key = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      wave.delete();
      add_run(1, 3); add_run(0, 30);
      run_wave(1'b1, "heldreset");
      check_str("heldreset events", ev_str, "ose");

      // Random key waveforms against the model.
      for (int s = 0; s < 3; s++) begin
         wave.delete();
         for (int r = 0; r < 40; r++) begin
            int g;
            add_run(1'b1, $urandom_range(1, 9));
            g = ($urandom_range(0, 9) < 6) ? $urandom_range(1, 6) : $urandom_range(7, 30);
            add_run(1'b0, g);
         end
         add_run(1'b0, 30);
         run_wave(1'b0, $sformatf("rand%0d", s));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/morse_key_timer.md
# morse_key_timer

Front-end stage that turns a single raw telegraph key input into the one-cycle Dot, Dash, Space and EndSeq pulses consumed by morse_code_encoder. It sits directly upstream of the encoder and sequence_producer pair. The block synchronizes and debounces the key, classifies each press by its duration, and emits letter and message separators based on silence length. It also enforces the 5-symbol-per-letter limit of sequence_producer.

## Interface
- CW, 16: width of all duration counters; counters saturate at 2^CW-1.
- DEBOUNCE, 4: consecutive stable cycles required to accept a key level change (>=1).
- DASH_MIN, 300: debounced press length in cycles at or above which the press is a Dash; shorter presses are a Dot (>=1).
- SPACE_GAP, 900: silence in cycles after a symbol that closes the letter.
- END_GAP, 2100: silence in cycles after a symbol that closes the message. Must satisfy SPACE_GAP < END_GAP < 2^CW.
- Clk, input, 1: sole clock, rising edge.
- Reset, input, 1: synchronous, active-high.
- Key, input, 1: raw asynchronous key, 1 = pressed.
- Dot, output, 1: one-cycle pulse, short press accepted.
- Dash, output, 1: one-cycle pulse, long press accepted.
- Space, output, 1: one-cycle pulse, letter closed.
- EndSeq, output, 1: one-cycle pulse, message closed.
- Overrun, output, 1: one-cycle pulse, a sixth press in one letter was discarded.
- SymCount, output, 3: number of symbols accepted in the current letter (0..5).

## Operation
- Key passes through a 2-flop synchronizer to key_s, then the debouncer produces key_d.
- key_d takes the value of key_s only after key_s has differed from key_d for DEBOUNCE consecutive cycles. Shorter glitches are ignored.
- States:
  - IDLE: no open message.
  - PRESS: key_d high, counting press length.
  - GAP: letter open, counting silence.
  - WORD_WAIT: letter closed by Space, message still open, counting silence.
- Transitions into PRESS: IDLE, GAP or WORD_WAIT go to PRESS on a key_d rise. press_cnt is cleared to 1 on entry.
- PRESS to GAP on a key_d fall:
  - If SymCount < 5: pulse Dot if press_cnt < DASH_MIN, else pulse Dash, and increment SymCount.
  - If SymCount == 5: pulse Overrun only; SymCount is unchanged.
  - In both cases gap_cnt restarts at 0.
- GAP to WORD_WAIT when gap_cnt reaches SPACE_GAP: pulse Space and clear SymCount to 0.
- WORD_WAIT to IDLE when gap_cnt reaches END_GAP: pulse EndSeq.
- A press during GAP continues the current letter with no Space emitted.
- A press during WORD_WAIT starts a new letter. No EndSeq is emitted.
- IDLE emits nothing regardless of silence length, so separators are never repeated.
- At most one output pulse is asserted in any cycle.
- Counters saturate and never wrap. A press longer than 2^CW-1 cycles is a Dash.

## Timing
- Reset values: every output 0, SymCount 0, state IDLE. Synchronizer, debouncer and counters are all cleared.
- Key-edge to key_d-edge latency: 2 + DEBOUNCE cycles, identical for rise and fall, so press length is preserved.
- Dot/Dash/Overrun: registered, asserted the cycle after key_d falls. Latency from raw release is 3 + DEBOUNCE cycles.
- Space: asserted exactly SPACE_GAP cycles after the last Dot/Dash/Overrun pulse, provided no press intervenes.
- EndSeq: asserted exactly END_GAP cycles after that same pulse, provided no press intervenes.
- SymCount updates in the same cycle as the Dot/Dash or Space pulse.
- Reset asserted mid-press discards the press with no pulse. If Key is still high after reset deasserts, it is treated as a fresh press after the debounce latency.

## Structure
- Shared package morse_pkg:
  - MAX_SYMBOLS = 5, also used by sequence_producer.
  - State enum key_state_t {IDLE, PRESS, GAP, WORD_WAIT}.
- Sub-module key_debouncer (parameter DEBOUNCE): contains the synchronizer and stability counter, and outputs key_d.
- The top level holds the FSM, press_cnt, gap_cnt and SymCount.

## Test plan
All scenarios use DEBOUNCE=2, DASH_MIN=5, SPACE_GAP=8, END_GAP=16, CW=8.
- Reset: hold Reset 3 cycles with Key toggling -> all outputs 0 and SymCount 0 throughout and after release.
- Single Dot: Key high 3 cycles -> one Dot 5 cycles after release, SymCount=1. Space 8 cycles after Dot with SymCount=0. EndSeq 16 cycles after Dot. Nothing further over the next 100 cycles.
- Letter L: presses of 3, 6, 3, 3 cycles separated by 4-cycle gaps -> Dot, Dash, Dot, Dot, with SymCount stepping 1 through 4, then one Space and one EndSeq. Feeding this through the encoder and sequence_producer gives EncSeq symbols 00, 01, 00, 00.
- Glitch: Key high 1 cycle -> no output, state stays IDLE.
- Overrun: six 3-cycle presses with 4-cycle gaps -> five Dots, then Overrun on the sixth. SymCount holds 5, then clears at the Space.
- New letter in WORD_WAIT: Dot, then a press starting 12 cycles after the Dot -> Space at 8, no EndSeq, a new Dot with SymCount=1. Separately, Reset asserted mid-press -> no Dot.
